calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; ports are listed below with clock and reset first.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  synchronous active-low reset.
REQ-004 Port: start  input  1  request to run one operation; sampled only in IDLE.
REQ-005 Port: op  input  2  operation code: 00 ADD, 01 SUB, 10 NEG (negate A), 11 PASS (copy A).
REQ-006 Port: addr_a, addr_b, addr_c  input  2 each  operand A, operand B and result word addresses.
REQ-007 Port: busy  output  1  high in every state except IDLE.
REQ-008 Port: done  output  1  one-cycle completion pulse.
REQ-009 Port: result  output  16  last computed signed result, held until the next EXEC.
REQ-010 Port: ovf  output  1  signed overflow of the last operation, held with result.
REQ-011 Port: mem_addr  output  2  memory word address.
REQ-012 Port: mem_wdata  output  16  memory write data.
REQ-013 Port: mem_rdata  input  16  memory read data (valid while cs & oe & !we, one cycle after the read is issued).
REQ-014 Port: cs, we, oe  output  1 each  memory chip select, write enable and output enable.

Function
REQ-015 States SHALL be IDLE, RD_A, WAIT_A, RD_B, WAIT_B, EXEC, WR_C and DONE; each non-IDLE state lasts exactly one cycle, in that order.
REQ-016 In IDLE with start=1, op and all three addresses SHALL be latched and the next state SHALL be RD_A; later changes to the inputs SHALL NOT affect the running operation.
REQ-017 start while busy=1 SHALL be ignored; it is neither queued nor counted.
REQ-018 RD_A and WAIT_A: cs=1, we=0, oe=1, mem_addr=latched addr_a; operand A SHALL be captured from mem_rdata at the end of WAIT_A.
REQ-019 RD_B and WAIT_B: same as REQ-018 using addr_b; operand B SHALL be captured at the end of WAIT_B.
REQ-020 For op NEG and PASS, the B reads SHALL still be performed, so latency is fixed.
REQ-021 EXEC: cs=0; result and ovf SHALL be registered from the ALU.
REQ-022 ALU arithmetic: 16-bit two's complement, wrap-around; ADD ovf = operands of equal sign with result sign differing; SUB ovf = operands of differing sign with result sign differing from A; NEG ovf = 1 only for A=16'h8000 (result 16'h8000); PASS ovf = 0.
REQ-023 WR_C: cs=1, we=1, oe=0, mem_addr=latched addr_c, mem_wdata=result.
REQ-024 DONE: done=1 and cs=0; the next state SHALL be IDLE. A start in DONE SHALL be ignored; the next accepted start is in IDLE.
REQ-025 Latency: done SHALL be high in the 7th cycle after the start-accept edge; a back-to-back start gives one operation per 8 cycles.
REQ-026 addr_a=addr_b and addr_c equal to a source address SHALL be legal; the write occurs after both reads.
REQ-027 Outside REQ-018, REQ-019 and REQ-023: cs=0, we=0, oe=0, mem_wdata=0 and mem_addr=0.

Reset
REQ-028 When rst_n=0 at a clock edge: state SHALL become IDLE; busy, done, ovf, cs, we and oe SHALL be 0; result, mem_addr, mem_wdata and the operand registers SHALL be 0.
REQ-029 Reset during any state, including WR_C, SHALL abort the operation with no done pulse; the write is not retried.

Structure
REQ-030 A shared package calc_pkg SHALL hold the op enum, the state enum, and the constants DATA_W=16 and ADDR_W=2.
REQ-031 The ALU SHALL be a separate combinational sub-module calc_alu (inputs a, b, op; outputs y, ovf), instantiated once.

Verification
REQ-032 Memory preloaded {0:16'h0005, 1:16'h0003}; ADD a=0, b=1, c=2 -> done at cycle 7, mem[2]=16'h0008, ovf=0.
REQ-033 mem[0]=16'h7FFF, mem[1]=16'h0001, ADD to c=3 -> mem[3]=16'h8000, ovf=1; then SUB of 16'h8000 minus 16'h0001 -> 16'h7FFF, ovf=1.
REQ-034 NEG a=0 with mem[0]=16'h8000, c=0 -> mem[0]=16'h8000, ovf=1; PASS of 16'hFFFF -> copied unchanged, ovf=0.
REQ-035 start pulsed in RD_B and held high through DONE -> exactly one write for the first request; second operation accepted in the following IDLE, done 8 cycles after the first done.
REQ-036 rst_n=0 during WR_C -> next cycle IDLE, all outputs 0, no done pulse; a subsequent ADD completes normally.

Source files
------------

// File: rtl/calc_sequencer_pkg.sv
// calc_pkg: shared types and widths for the calc_sequencer block.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package calc_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NEG  = 2'b10,
    OP_PASS = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_A   = 3'd1,
    ST_WAIT_A = 3'd2,
    ST_RD_B   = 3'd3,
    ST_WAIT_B = 3'd4,
    ST_EXEC   = 3'd5,
    ST_WR_C   = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

endpackage

// File: rtl/calc_sequencer_alu.sv
// calc_alu: 16-bit two's complement ADD/SUB/NEG/PASS with signed overflow flag.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b operands; op operation code; y wrapped result; ovf signed overflow.
module calc_alu
  import calc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_t               op,
  output logic [DATA_W-1:0] y,
  output logic              ovf
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        y   = a + b;
        // Same-sign operands producing an opposite-sign sum.
        ovf = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        y   = a - b;
        // Differing-sign operands where the difference flips away from A.
        ovf = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
      OP_NEG: begin
        y   = '0 - a;
        // Only the most negative value has no positive counterpart.
        ovf = (a == MOST_NEG);
      end
      OP_PASS: begin
        y   = a;
        ovf = 1'b0;
      end
      default: begin
        y   = '0;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: reads A and B from a word memory, runs the ALU, writes the result to C.
// Latency: fixed 8-cycle operation, done pulses in the 7th cycle after start is accepted.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
// Ports: clk/rst_n (sync, active-low); start/op/addr_a/addr_b/addr_c request;
//        busy/done/result/ovf status; mem_addr/mem_wdata/mem_rdata/cs/we/oe memory port.
module calc_sequencer
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_c,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cs,
  output logic              we,
  output logic              oe
);

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_a_q;
  logic [ADDR_W-1:0] addr_b_q;
  logic [ADDR_W-1:0] addr_c_q;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] alu_y;
  logic              alu_ovf;

  calc_alu u_alu (
    .a   (opnd_a),
    .b   (opnd_b),
    .op  (op_q),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
      opnd_a   <= '0;
      opnd_b   <= '0;
      result   <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= op_t'(op);
            addr_a_q <= addr_a;
            addr_b_q <= addr_b;
            addr_c_q <= addr_c;
            state    <= ST_RD_A;
          end
        end
        ST_RD_A:   state <= ST_WAIT_A;
        // Read data is valid one cycle after the read is issued.
        ST_WAIT_A: begin
          opnd_a <= mem_rdata;
          state  <= ST_RD_B;
        end
        ST_RD_B:   state <= ST_WAIT_B;
        // B is read even for NEG/PASS so every op has the same latency.
        ST_WAIT_B: begin
          opnd_b <= mem_rdata;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          result <= alu_y;
          ovf    <= alu_ovf;
          state  <= ST_WR_C;
        end
        ST_WR_C:   state <= ST_DONE;
        ST_DONE:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from state so they drop to idle values
  // in the same cycle reset takes effect.
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    cs        = 1'b0;
    we        = 1'b0;
    oe        = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_RD_A, ST_WAIT_A: begin
        cs       = 1'b1;
        oe       = 1'b1;
        mem_addr = addr_a_q;
      end
      ST_RD_B, ST_WAIT_B: begin
        cs       = 1'b1;
        oe       = 1'b1;
        mem_addr = addr_b_q;
      end
      ST_WR_C: begin
        cs        = 1'b1;
        we        = 1'b1;
        mem_addr  = addr_c_q;
        mem_wdata = result;
      end
      default: begin
        cs = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and randomized checks of calc_sequencer against
// an arithmetic reference model and a simple synchronous-read word memory.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [1:0]  addr_a = 2'd0;
  logic [1:0]  addr_b = 2'd0;
  logic [1:0]  addr_c = 2'd0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic [1:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        cs;
  logic        we;
  logic        oe;

  logic [15:0] mem [4];
  logic        load_en = 1'b0;
  logic [1:0]  load_addr = 2'd0;
  logic [15:0] load_data = 16'd0;
  int          write_count = 0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .addr_c    (addr_c),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cs        (cs),
    .we        (we),
    .oe        (oe)
  );

  // Word memory: registered read data, write on the clock edge.
  always @(posedge clk) begin
    if (cs && oe && !we) mem_rdata <= mem[mem_addr];
    if (cs && we) begin
      mem[mem_addr] <= mem_wdata;
      write_count   <= write_count + 1;
    end
    if (load_en) mem[load_addr] <= load_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: widen to int, do exact arithmetic, detect out-of-range.
  function automatic void ref_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] y, output logic ov);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (o)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = -sa;
      default: r = sa;
    endcase
    y  = r[15:0];
    ov = (r > 32767) || (r < -32768);
  endfunction

  // Expected {busy,done,cs,we,oe,mem_addr,mem_wdata} in cycle n after accept.
  function automatic logic [22:0] bus_exp(input int n, input logic [1:0] ra, input logic [1:0] rb,
                                          input logic [1:0] rc, input logic [15:0] y);
    case (n)
      1, 2:    return {5'b10101, ra, 16'h0};
      3, 4:    return {5'b10101, rb, 16'h0};
      5:       return {5'b10000, 2'd0, 16'h0};
      6:       return {5'b10110, rc, y};
      7:       return {5'b11000, 2'd0, 16'h0};
      default: return {5'b00000, 2'd0, 16'h0};
    endcase
  endfunction

  function automatic logic [22:0] bus_now();
    return {busy, done, cs, we, oe, mem_addr, mem_wdata};
  endfunction

  task automatic load(input logic [1:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rc);
    logic [15:0] ey, src_a, src_b;
    logic        eo;
    int          cyc, w0;
    src_a = mem[ra];
    src_b = mem[rb];
    ref_op(o, src_a, src_b, ey, eo);
    w0     = write_count;
    op     = o;
    addr_a = ra;
    addr_b = rb;
    addr_c = rc;
    start  = 1'b1;
    cyc    = 0;
    do begin
      @(negedge clk);
      cyc++;
      // Scramble request inputs; the running op must use the latched copy.
      start  = 1'b0;
      op     = 2'($urandom);
      addr_a = 2'($urandom);
      addr_b = 2'($urandom);
      addr_c = 2'($urandom);
      if (cyc <= 7) check($sformatf("bus_c%0d", cyc), 32'(bus_now()), 32'(bus_exp(cyc, ra, rb, rc, ey)));
    end while (!done && cyc < 20);
    check("latency", 32'(cyc), 32'd7);
    check("result", 32'(result), 32'(ey));
    check("ovf", 32'(ovf), 32'(eo));
    check("mem_c", 32'(mem[rc]), 32'(ey));
    check("writes", 32'(write_count - w0), 32'd1);
    @(negedge clk);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] ey2;
    logic        eo2;
    int          first_done, second_done, w0, dcount;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_bus", 32'(bus_now()), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5 + 3 = 8.
    load(2'd0, 16'h0005);
    load(2'd1, 16'h0003);
    run_op(2'd0, 2'd0, 2'd1, 2'd2);
    check("add_basic", 32'(mem[2]), 32'h0008);

    // 7FFF + 1 overflows, then 8000 - 1 overflows back.
    load(2'd0, 16'h7FFF);
    load(2'd1, 16'h0001);
    run_op(2'd0, 2'd0, 2'd1, 2'd3);
    check("add_ovf_val", 32'(mem[3]), 32'h8000);
    run_op(2'd1, 2'd3, 2'd1, 2'd2);
    check("sub_ovf_val", 32'(mem[2]), 32'h7FFF);

    // NEG of most-negative in place, PASS of FFFF, and A==B==C.
    load(2'd0, 16'h8000);
    run_op(2'd2, 2'd0, 2'd0, 2'd0);
    check("neg_min", 32'(mem[0]), 32'h8000);
    load(2'd2, 16'hFFFF);
    run_op(2'd3, 2'd2, 2'd1, 2'd1);
    check("pass_ffff", 32'(mem[1]), 32'hFFFF);
    run_op(2'd0, 2'd1, 2'd1, 2'd1);

    // Start raised in RD_B and held through DONE: only accepted in the next IDLE.
    load(2'd0, 16'h0010);
    load(2'd1, 16'h0020);
    load(2'd2, 16'h0001);
    load(2'd3, 16'h0100);
    w0 = write_count;
    first_done = 0;
    second_done = 0;
    ey2 = 16'h0;
    eo2 = 1'b0;
    op = 2'd0; addr_a = 2'd0; addr_b = 2'd1; addr_c = 2'd2;
    start = 1'b1;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 3) begin
        start = 1'b1; op = 2'd1; addr_a = 2'd2; addr_b = 2'd3; addr_c = 2'd3;
      end
      if (cyc == 9) start = 1'b0;
      if (done) begin
        if (first_done == 0) first_done = cyc;
        else if (second_done == 0) second_done = cyc;
      end
      if (cyc == 7) begin
        check("held_one_write", 32'(write_count - w0), 32'd1);
        ref_op(2'd1, mem[2], mem[3], ey2, eo2);
      end
    end
    check("held_first_done", 32'(first_done), 32'd7);
    check("held_second_done", 32'(second_done), 32'd15);
    check("held_total_writes", 32'(write_count - w0), 32'd2);
    check("held_mem", 32'(mem[3]), 32'(ey2));
    check("held_ovf", 32'(ovf), 32'(eo2));

    // Reset while in WR_C aborts without a done pulse.
    load(2'd0, 16'h1234);
    load(2'd1, 16'h1111);
    op = 2'd0; addr_a = 2'd0; addr_b = 2'd1; addr_c = 2'd3;
    start = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("in_wrc", 32'(we), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_bus", 32'(bus_now()), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    run_op(2'd0, 2'd0, 2'd1, 2'd2);

    // Randomized ops with corner-biased memory contents.
    repeat (40) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) begin
          case ($urandom_range(0, 5))
            0:       load(2'(i), 16'h8000);
            1:       load(2'(i), 16'h7FFF);
            2:       load(2'(i), 16'hFFFF);
            default: load(2'(i), 16'($urandom));
          endcase
        end
      end
      run_op(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
